// File: rtl/rc_channel_scheduler_pkg.sv
// Shared constants and FSM encoding for the RC
// receiver channel scheduler.
package rc_pkg;

  localparam int RC_CNT_W        = 11;
  localparam int RC_MIN_CNT      = 625;
  localparam int RC_MAX_CNT      = 1250;
  localparam int RC_TIMEOUT_CYC  = 15625;
  localparam int RC_FAILSAFE_VAL = 625;
  localparam int RC_CH_W         = 3;
  localparam int RC_MAX_CH       = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } rc_state_e;

endpackage

// File: rtl/rc_channel_scheduler_if.sv
// Serial result stream handshake between the
// scheduler and the flight-control core.
interface rc_channel_scheduler_if;
  import rc_pkg::*;

  logic                out_valid;
  logic                out_ready;
  logic [RC_CH_W-1:0]  out_chan;
  logic [RC_CNT_W-1:0] out_value;
  logic                out_failsafe;

  modport master (
    output out_valid,
    output out_chan,
    output out_value,
    output out_failsafe,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_chan,
    input  out_value,
    input  out_failsafe,
    output out_ready
  );

endinterface

// File: rtl/rc_channel_scheduler_watchdog.sv
// Per-channel capture, clamp, signal-loss watchdog
// and pending/stale flags.
module rc_channel_watchdog
  import rc_pkg::*;
#(
  parameter int CNT_W        = RC_CNT_W,
  parameter int MIN_CNT      = RC_MIN_CNT,
  parameter int MAX_CNT      = RC_MAX_CNT,
  parameter int TIMEOUT      = RC_TIMEOUT_CYC,
  parameter int FAILSAFE_VAL = RC_FAILSAFE_VAL
) (
  input  logic             clk_system,
  input  logic             reset_n,
  input  logic             done_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             clr_pend_i,
  output logic [CNT_W-1:0] hold_o,
  output logic             pend_o,
  output logic             stale_o
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0]  wdog_q;
  logic [CNT_W-1:0] hold_q;
  logic             pend_q;
  logic             stale_q;
  logic [CNT_W-1:0] clamp_d;
  logic             wd_hit;

  always_comb begin
    clamp_d = count_i;
    if (count_i < CNT_W'(MIN_CNT))
      clamp_d = CNT_W'(MIN_CNT);
    else if (count_i > CNT_W'(MAX_CNT))
      clamp_d = CNT_W'(MAX_CNT);
  end

  assign wd_hit = wdog_q == WD_W'(TIMEOUT - 1);

  // A fresh strobe beats both the timeout and a grant-side clear
  always_ff @(posedge clk_system or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q  <= '0;
      hold_q  <= CNT_W'(FAILSAFE_VAL);
      pend_q  <= 1'b0;
      stale_q <= 1'b0;
    end else if (done_i) begin
      wdog_q  <= '0;
      hold_q  <= clamp_d;
      pend_q  <= 1'b1;
      stale_q <= 1'b0;
    end else begin
      if (clr_pend_i)
        pend_q <= 1'b0;
      if (wdog_q != WD_W'(TIMEOUT))
        wdog_q <= wdog_q + 1'b1;
      if (wd_hit) begin
        stale_q <= 1'b1;
        hold_q  <= CNT_W'(FAILSAFE_VAL);
        pend_q  <= 1'b1;
      end
    end
  end

  assign hold_o  = hold_q;
  assign pend_o  = pend_q;
  assign stale_o = stale_q;

endmodule

// File: rtl/rc_channel_scheduler.sv
// Round-robin serialiser of RC channel results with
// failsafe substitution and frame completion strobe.
module rc_channel_scheduler
  import rc_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = RC_CNT_W,
  parameter int MIN_CNT      = RC_MIN_CNT,
  parameter int MAX_CNT      = RC_MAX_CNT,
  parameter int TIMEOUT      = RC_TIMEOUT_CYC,
  parameter int FAILSAFE_VAL = RC_FAILSAFE_VAL
) (
  input  logic                    clk_system,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       chan_done,
  input  logic [NUM_CH*CNT_W-1:0] chan_count,
  rc_channel_scheduler_if.master  out_if,
  output logic                    failsafe_any,
  output logic                    frame_strobe
);

  logic [CNT_W-1:0]     hold [RC_MAX_CH];
  logic [RC_MAX_CH-1:0] pend_v;
  logic [RC_MAX_CH-1:0] stale_v;
  logic [NUM_CH-1:0]    clr_pend;

  rc_state_e            state_q;
  logic [RC_CH_W-1:0]   ptr_q;
  logic [NUM_CH-1:0]    seen_q;
  logic                 out_valid_q;
  logic [RC_CH_W-1:0]   out_chan_q;
  logic [CNT_W-1:0]     out_value_q;
  logic                 out_fs_q;
  logic                 fs_any_q;
  logic                 frame_q;

  logic                 gnt_vld;
  logic [RC_CH_W-1:0]   gnt_idx;
  logic [RC_CH_W:0]     sum;
  logic                 acc;
  logic [NUM_CH-1:0]    acc_mask;
  logic [RC_CH_W-1:0]   next_ptr;

  for (genvar i = 0; i < RC_MAX_CH; i++) begin : g_ch
    if (i < NUM_CH) begin : g_on
      assign clr_pend[i] = (state_q == ST_IDLE) && gnt_vld
                           && (gnt_idx == RC_CH_W'(i));
      rc_channel_watchdog #(
        .CNT_W        (CNT_W),
        .MIN_CNT      (MIN_CNT),
        .MAX_CNT      (MAX_CNT),
        .TIMEOUT      (TIMEOUT),
        .FAILSAFE_VAL (FAILSAFE_VAL)
      ) u_wd (
        .clk_system (clk_system),
        .reset_n    (reset_n),
        .done_i     (chan_done[i]),
        .count_i    (chan_count[i*CNT_W +: CNT_W]),
        .clr_pend_i (clr_pend[i]),
        .hold_o     (hold[i]),
        .pend_o     (pend_v[i]),
        .stale_o    (stale_v[i])
      );
    end else begin : g_off
      assign hold[i]    = '0;
      assign pend_v[i]  = 1'b0;
      assign stale_v[i] = 1'b0;
    end
  end

  // First pending channel at or after the pointer, wrapping
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = {1'b0, ptr_q} + (RC_CH_W+1)'(k);
      if (sum >= (RC_CH_W+1)'(NUM_CH))
        sum = sum - (RC_CH_W+1)'(NUM_CH);
      if (!gnt_vld && pend_v[sum[RC_CH_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = sum[RC_CH_W-1:0];
      end
    end
  end

  assign acc = (state_q == ST_SEND) && out_if.out_ready;

  always_comb begin
    acc_mask = '0;
    for (int i = 0; i < NUM_CH; i++)
      acc_mask[i] = acc && (out_chan_q == RC_CH_W'(i));
  end

  assign next_ptr = (out_chan_q == RC_CH_W'(NUM_CH - 1))
                    ? '0 : out_chan_q + 1'b1;

  always_ff @(posedge clk_system or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      seen_q      <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_value_q <= '0;
      out_fs_q    <= 1'b0;
      fs_any_q    <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      fs_any_q <= |stale_v;
      if (&seen_q) begin
        frame_q <= 1'b1;
        seen_q  <= acc_mask;
      end else begin
        frame_q <= 1'b0;
        seen_q  <= seen_q | acc_mask;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (gnt_vld) begin
            out_valid_q <= 1'b1;
            out_chan_q  <= gnt_idx;
            out_value_q <= hold[gnt_idx];
            out_fs_q    <= stale_v[gnt_idx];
            state_q     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (out_if.out_ready) begin
            out_valid_q <= 1'b0;
            ptr_q       <= next_ptr;
            state_q     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign out_if.out_valid    = out_valid_q;
  assign out_if.out_chan     = out_chan_q;
  assign out_if.out_value    = out_value_q;
  assign out_if.out_failsafe = out_fs_q;
  assign failsafe_any        = fs_any_q;
  assign frame_strobe        = frame_q;

endmodule

// File: tb/tb_rc_channel_scheduler.sv
// Directed and randomised bench for rc_channel_scheduler
// against a per-channel behavioural reference model.
module tb_rc_channel_scheduler;

  localparam int N  = 4;
  localparam int W  = 11;
  localparam int TO = 15625;
  localparam int FS = 625;

  logic           clk_system;
  logic           reset_n;
  logic [N-1:0]   chan_done;
  logic [N*W-1:0] chan_count;
  logic           failsafe_any;
  logic           frame_strobe;

  rc_channel_scheduler_if bus();

  rc_channel_scheduler #(.NUM_CH(N)) dut (
    .clk_system   (clk_system),
    .reset_n      (reset_n),
    .chan_done    (chan_done),
    .chan_count   (chan_count),
    .out_if       (bus),
    .failsafe_any (failsafe_any),
    .frame_strobe (frame_strobe)
  );

  initial clk_system = 1'b0;
  always #5 clk_system = ~clk_system;

  int n_pass;
  int n_total;
  int n_frame;

  int acc_ch[$];
  int acc_val[$];
  bit acc_fs[$];

  int m_val[N];
  bit m_pend[N];
  bit m_stale[N];
  int m_age[N];
  bit m_seen[N];
  bit m_busy;
  int m_chan;
  int m_value;
  bit m_fs;
  bit m_frame;
  bit m_fsany;
  int m_ptr;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int clampv(int c);
    if (c < 625) return 625;
    if (c > 1250) return 1250;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_val[i] = FS; m_pend[i] = 0; m_stale[i] = 0;
      m_age[i] = 0;  m_seen[i] = 0;
    end
    m_busy = 0; m_chan = 0; m_value = 0; m_fs = 0;
    m_frame = 0; m_fsany = 0; m_ptr = 0;
  endtask

  // One clock edge of the specified behaviour, using pre-edge state
  task automatic model_step();
    bit acc;
    bit all;
    bit any_stale;
    int g;
    acc = m_busy && bus.out_ready;
    g = -1;
    if (!m_busy)
      for (int k = 0; k < N; k++)
        if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    all = 1;
    any_stale = 0;
    for (int i = 0; i < N; i++) begin
      if (!m_seen[i]) all = 0;
      if (m_stale[i]) any_stale = 1;
    end
    if (all) for (int i = 0; i < N; i++) m_seen[i] = 0;
    m_frame = all;
    if (acc) m_seen[m_chan] = 1;
    if (g >= 0) begin
      m_busy = 1; m_chan = g; m_value = m_val[g];
      m_fs = m_stale[g]; m_pend[g] = 0;
    end else if (acc) begin
      m_busy = 0; m_ptr = (m_chan + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (chan_done[i]) begin
        m_val[i] = clampv(int'(chan_count[i*W +: W]));
        m_pend[i] = 1; m_stale[i] = 0; m_age[i] = 0;
      end else if (m_age[i] < TO) begin
        m_age[i]++;
        if (m_age[i] == TO) begin
          m_stale[i] = 1; m_val[i] = FS; m_pend[i] = 1;
        end
      end
    end
    m_fsany = any_stale;
  endtask

  task automatic tick();
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      acc_ch.push_back(int'(bus.out_chan));
      acc_val.push_back(int'(bus.out_value));
      acc_fs.push_back(bus.out_failsafe);
    end
    @(posedge clk_system);
    if (reset_n) model_step();
    @(negedge clk_system);
    chk("out_valid", bus.out_valid, m_busy);
    chk("out_chan", bus.out_chan, m_chan);
    chk("out_value", bus.out_value, m_value);
    chk("out_failsafe", bus.out_failsafe, m_fs);
    chk("failsafe_any", failsafe_any, m_fsany);
    chk("frame_strobe", frame_strobe, m_frame);
    if (frame_strobe === 1'b1) n_frame++;
  endtask

  task automatic pulse(int ch, int cnt);
    chan_done[ch] = 1'b1;
    chan_count[ch*W +: W] = W'(cnt);
    tick();
    chan_done = '0;
  endtask

  task automatic do_reset();
    chan_done = '0;
    reset_n = 1'b0;
    model_reset();
    @(negedge clk_system);
    @(negedge clk_system);
    reset_n = 1'b1;
  endtask

  initial begin
    int s;
    int nfs;
    int last2;
    n_pass = 0; n_total = 0; n_frame = 0;
    chan_done = '0; chan_count = '0; bus.out_ready = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_system);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_chan", bus.out_chan, 0);
    chk("rst_value", bus.out_value, 0);
    chk("rst_fs", bus.out_failsafe, 0);
    chk("rst_fsany", failsafe_any, 0);
    chk("rst_frame", frame_strobe, 0);
    reset_n = 1'b1;

    // nominal capture and clamping
    bus.out_ready = 1'b1;
    pulse(1, 937);
    tick();
    chk("nom_valid", bus.out_valid, 1);
    chk("nom_chan", bus.out_chan, 1);
    chk("nom_value", bus.out_value, 937);
    chk("nom_fs", bus.out_failsafe, 0);
    tick();
    chk("nom_accept", bus.out_valid, 0);
    pulse(0, 1400);
    tick();
    chk("clamp_hi", bus.out_value, 1250);
    tick();
    pulse(0, 500);
    tick();
    chk("clamp_lo", bus.out_value, 625);
    tick();

    // round-robin with backpressure from a fresh frame
    do_reset();
    n_frame = 0;
    bus.out_ready = 1'b0;
    chan_done = 4'b1101;
    chan_count[0*W +: W] = W'(625);
    chan_count[2*W +: W] = W'(1000);
    chan_count[3*W +: W] = W'(1250);
    tick();
    chan_done = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_chan", bus.out_chan, 0);
      chk("stall_value", bus.out_value, 625);
    end
    s = acc_ch.size();
    bus.out_ready = 1'b1;
    repeat (8) tick();
    chk("rr_count", acc_ch.size() - s, 3);
    chk("rr_0", (acc_ch.size() > s) ? acc_ch[s] : -1, 0);
    chk("rr_1", (acc_ch.size() > s + 1) ? acc_ch[s+1] : -1, 2);
    chk("rr_2", (acc_ch.size() > s + 2) ? acc_ch[s+2] : -1, 3);
    chk("rr_val2", (acc_val.size() > s + 2) ? acc_val[s+2] : -1, 1250);
    chk("frame_early", n_frame, 0);
    pulse(1, 600);
    repeat (6) tick();
    chk("frame_once", n_frame, 1);

    // ch2 starves while the other channels keep reporting
    s = acc_ch.size();
    for (int t = 0; t < 19000; t++) begin
      if (t % 1000 == 0) begin
        chan_done = 4'b1011;
        for (int c = 0; c < N; c++)
          chan_count[c*W +: W] = W'($urandom_range(400, 1500));
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
      chan_done = '0;
    end
    bus.out_ready = 1'b1;
    repeat (10) tick();
    chk("to_fsany", failsafe_any, 1);
    nfs = 0;
    for (int i = s; i < acc_ch.size(); i++)
      if (acc_ch[i] == 2) begin
        nfs++;
        chk("to_fs_val", acc_val[i], 625);
        chk("to_fs_flag", acc_fs[i], 1);
      end
    chk("to_fs_words", nfs, 1);
    pulse(2, 900);
    repeat (5) tick();
    chk("rec_fsany", failsafe_any, 0);
    chk("rec_chan", acc_ch[$], 2);
    chk("rec_value", acc_val[$], 900);
    chk("rec_fs", acc_fs[$], 0);

    // overwrite while the channel's word is in flight
    do_reset();
    bus.out_ready = 1'b0;
    pulse(3, 700);
    tick();
    pulse(3, 1100);
    chk("ovr_hold", bus.out_value, 700);
    bus.out_ready = 1'b1;
    repeat (6) tick();
    last2 = acc_ch.size() - 2;
    chk("ovr_ch_a", acc_ch[last2], 3);
    chk("ovr_val_a", acc_val[last2], 700);
    chk("ovr_ch_b", acc_ch[last2+1], 3);
    chk("ovr_val_b", acc_val[last2+1], 1100);

    // randomised traffic
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < N; c++) begin
        chan_done[c] = ($urandom_range(0, 15) == 0);
        chan_count[c*W +: W] = W'($urandom_range(0, 2047));
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    chan_done = '0;

    // asynchronous reset while a word is held
    bus.out_ready = 1'b0;
    pulse(0, 1000);
    repeat (3) tick();
    chk("pre_rst_valid", bus.out_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_chan", bus.out_chan, 0);
    chk("arst_value", bus.out_value, 0);
    chk("arst_fs", bus.out_failsafe, 0);
    chk("arst_fsany", failsafe_any, 0);
    model_reset();
    @(negedge clk_system);
    @(negedge clk_system);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    s = acc_ch.size();
    repeat (100) tick();
    chk("post_rst_words", acc_ch.size() - s, 0);
    chk("post_rst_valid", bus.out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
